// File: rtl/mm_result_drain.sv
// rtl/mm_result_drain.sv - buffers 40-bit engine results and drains them as two 20-bit beats
module mm_result_drain #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mm_read,
    input  logic        mm_write,
    input  logic [39:0] mm_data,
    input  logic        mm_finish,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [19:0] out_data,
    output logic        out_hi,
    output logic [19:0] out_addr,
    output logic        overflow,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, HI, LO} state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [39:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    state_t        state_q, state_d;
    logic [39:0]   hold_q, hold_d;
    logic          out_valid_q, out_valid_d;
    logic [19:0]   out_data_q, out_data_d;
    logic          out_hi_q, out_hi_d;
    logic [19:0]   out_addr_q, out_addr_d;
    logic          overflow_q, overflow_d;
    logic          done_q, done_d;
    logic          finish_seen_q, finish_seen_d;

    logic          push, push_ok, pop, full, empty;
    logic [39:0]   head;

    always_comb begin
        push          = mm_write & ~mm_read;
        full          = (count_q == FULL_CNT);
        empty         = (count_q == '0);
        head          = mem_q[rd_ptr_q];
        pop           = 1'b0;
        state_d       = state_q;
        hold_d        = hold_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_hi_d      = out_hi_q;
        out_addr_d    = out_addr_q;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    hold_d      = head;
                    state_d     = HI;
                    out_valid_d = 1'b1;
                    out_hi_d    = 1'b1;
                    out_data_d  = head[39:20];
                end
            end
            HI: begin
                if (out_ready) begin
                    state_d    = LO;
                    out_hi_d   = 1'b0;
                    out_data_d = hold_q[19:0];
                end
            end
            LO: begin
                if (out_ready) begin
                    out_addr_d = out_addr_q + 20'd1;
                    // Refill straight from the FIFO so consecutive results have no bubble.
                    if (!empty) begin
                        pop         = 1'b1;
                        hold_d      = head;
                        state_d     = HI;
                        out_hi_d    = 1'b1;
                        out_data_d  = head[39:20];
                    end else begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        push_ok    = push & (~full | pop);
        overflow_d = overflow_q | (push & full & ~pop);

        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        finish_seen_d = finish_seen_q | mm_finish;
        done_d        = done_q | (finish_seen_q & empty & (state_q == IDLE) & ~push);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= mm_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= IDLE;
            hold_q        <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_hi_q      <= 1'b0;
            out_addr_q    <= '0;
            overflow_q    <= 1'b0;
            done_q        <= 1'b0;
            finish_seen_q <= 1'b0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            hold_q        <= hold_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_hi_q      <= out_hi_d;
            out_addr_q    <= out_addr_d;
            overflow_q    <= overflow_d;
            done_q        <= done_d;
            finish_seen_q <= finish_seen_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_hi    = out_hi_q;
    assign out_addr  = out_addr_q;
    assign overflow  = overflow_q;
    assign done      = done_q;

endmodule
